i_fetch_ctrl: RTL and testbench
===============================

Name: i_fetch_ctrl

Overview:
- Instruction fetch sequencer for the asynchronous instruction ROM.
- Owns the PC and drives the ROM address every cycle.
- Captures returned words into a small FIFO of {pc, instr} pairs and hands them to decode with a valid/ready handshake.
- Handles branch/jump redirects (flush plus new PC) and flags out-of-range or misaligned fetches as a sticky fault.

Parameters:
- address_data, 32, width of PC, ROM address and instruction word.
- memory_size, 256, ROM depth in words; valid word index 0..memory_size-1.
- reset_pc, 0, byte address loaded into the PC on reset.
- buf_depth, 2, FIFO entries; legal values 2 or 4.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- address  output  address_data  byte address to ROM; always equals fetch_pc.
- i_out  input  address_data  instruction word from ROM, combinational in address.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  address_data  target byte address.
- dec_valid  output  1  FIFO head valid.
- dec_ready  input  1  decode accepts head.
- dec_instr  output  address_data  head instruction.
- dec_pc  output  address_data  head PC.
- fault  output  1  sticky fetch fault.
- fault_pc  output  address_data  PC that caused the fault.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: fetch_pc=reset_pc, FIFO count=0, dec_valid=0, dec_instr=0, dec_pc=0, fault=0, fault_pc=0, state=RUN.
- States:
  - RUN: fetching.
  - FAULT: fetch stopped.
- push condition: state==RUN && index in range && (count<buf_depth || pop) && !redirect_valid.
  - index = fetch_pc[address_data-1:2]; in range means index < memory_size.
  - On push: write {fetch_pc, i_out} at tail; fetch_pc <= fetch_pc+4, wrapping mod 2^address_data.
  - Latency: ROM word at PC X is visible on dec_* the cycle after fetch_pc==X is pushed.
- pop condition: dec_valid && dec_ready && !redirect_valid; advances head.
- Push and pop in the same cycle: count unchanged; a full FIFO still accepts a push when popping.
- FIFO full and no pop: fetch_pc holds; address held stable.
- Out of range, state RUN, no redirect: no push; next cycle state=FAULT, fault=1, fault_pc=fetch_pc.
  - Already buffered entries still drain normally in FAULT.
- Redirect (highest priority):
  - Next cycle: FIFO flushed (count=0, dec_valid=0); the same-cycle push and pop are both suppressed.
  - The entry presented that cycle is NOT consumed, even if dec_ready=1.
  - redirect_pc[1:0]==0: fetch_pc<=redirect_pc, state<=RUN, fault<=0.
  - redirect_pc[1:0]!=0: fetch_pc<=redirect_pc, state<=FAULT, fault<=1, fault_pc<=redirect_pc.
- FAULT exits only via an aligned redirect or reset.
- dec_valid = (count!=0). dec_instr/dec_pc are registered head contents and hold stable while dec_valid && !dec_ready.
- Reset mid-stream: all of the above return to reset values next cycle, overriding redirect.
- Arithmetic: PC increment is unsigned address_data-bit. The range compare uses the full word index, so upper bits set = out of range.

Optional Feature:
- Macro: I_FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetches (32) and perf_stalls (32), both reset to 0.
  - perf_fetches increments on each push.
  - perf_stalls increments each cycle state==RUN && count==buf_depth && !pop && !redirect_valid.
  - Both saturate at 0xFFFFFFFF; neither is cleared by redirect.
- Not defined: ports absent, no counter logic; all other behaviour identical.

Test Plan:
- Streaming: reset, ROM[0..3]=0x20080001,0x20090002,0x01095020,0xAC0A0000, dec_ready=1 -> dec_valid from cycle 2; dec_pc 0,4,8,12 on consecutive cycles with the matching dec_instr.
- Backpressure: dec_ready=0 for 5 cycles with buf_depth=2 -> count saturates at 2, address holds 0x8, dec_pc holds 0x0. Release -> 0x0,0x4,0x8 in order, no loss or duplicate.
- Redirect: redirect_valid=1, redirect_pc=0x40 while dec_valid=1 and dec_ready=1 -> head not consumed, dec_valid=0 next cycle, address=0x40, then dec_pc=0x40 with ROM[16].
- Misaligned: redirect_pc=0x42 -> fault=1, fault_pc=0x42, no further pushes. Then redirect_pc=0x10 -> fault=0, fetch resumes at 0x10.
- Range end (memory_size=256): run to fetch_pc=0x3FC -> 0x3FC delivered; next cycle fault=1, fault_pc=0x400; buffered entries drain; dec_valid then stays 0.
- Reset mid-operation: reset asserted with count=2 and redirect_valid=1 -> next cycle count=0, address=reset_pc, fault=0. With I_FETCH_PERF_EN defined, perf counters read 0.

Source files
------------

// File: rtl/i_fetch_ctrl.sv
// rtl/i_fetch_ctrl.sv - instruction fetch sequencer feeding a {pc, instr} FIFO to decode
// Optional performance counters are enabled by defining I_FETCH_PERF_EN.
module i_fetch_ctrl #(
  parameter int                      address_data = 32,
  parameter int                      memory_size  = 256,
  parameter logic [address_data-1:0] reset_pc     = '0,
  parameter int                      buf_depth    = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [address_data-1:0] address,
  input  logic [address_data-1:0] i_out,
  input  logic                    redirect_valid,
  input  logic [address_data-1:0] redirect_pc,
  output logic                    dec_valid,
  input  logic                    dec_ready,
  output logic [address_data-1:0] dec_instr,
  output logic [address_data-1:0] dec_pc,
  output logic                    fault,
  output logic [address_data-1:0] fault_pc
`ifdef I_FETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetches,
  output logic [31:0]             perf_stalls
`endif
);

  localparam int                      IW        = (buf_depth > 2) ? 2 : 1;
  localparam logic [2:0]              DEPTH     = 3'(buf_depth);
  localparam logic [address_data-1:0] MEM_WORDS = address_data'(memory_size);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  logic [0:0]              r_state;
  logic [address_data-1:0] r_fetch_pc;
  logic                    r_fault;
  logic [address_data-1:0] r_fault_pc;
  logic [2:0]              r_count;
  logic [address_data-1:0] r_pc_q  [buf_depth];
  logic [address_data-1:0] r_ins_q [buf_depth];

  logic [address_data-1:0] w_pc_n  [buf_depth];
  logic [address_data-1:0] w_ins_n [buf_depth];
  logic                    w_in_range;
  logic                    w_pop;
  logic                    w_push;
  logic [IW-1:0]           w_wr_idx;

  assign w_in_range = (r_fetch_pc >> 2) < MEM_WORDS;
  assign w_pop      = (r_count != 3'd0) && dec_ready && !redirect_valid;
  assign w_push     = (r_state == ST_RUN) && w_in_range &&
                      ((r_count < DEPTH) || w_pop) && !redirect_valid;
  assign w_wr_idx   = IW'(r_count - {2'b00, w_pop});

  assign address   = r_fetch_pc;
  assign dec_valid = (r_count != 3'd0);
  assign dec_pc    = r_pc_q[0];
  assign dec_instr = r_ins_q[0];
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;

  // Shift-style FIFO: slot 0 is always the head, so dec_* come straight from flops.
  always_comb begin
    for (int i = 0; i < buf_depth; i++) begin
      w_pc_n[i]  = r_pc_q[i];
      w_ins_n[i] = r_ins_q[i];
    end
    if (w_pop) begin
      for (int i = 0; i < buf_depth - 1; i++) begin
        w_pc_n[i]  = r_pc_q[i+1];
        w_ins_n[i] = r_ins_q[i+1];
      end
    end
    if (w_push) begin
      w_pc_n[w_wr_idx]  = r_fetch_pc;
      w_ins_n[w_wr_idx] = i_out;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= reset_pc;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
      r_count    <= 3'd0;
      for (int i = 0; i < buf_depth; i++) begin
        r_pc_q[i]  <= '0;
        r_ins_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < buf_depth; i++) begin
        r_pc_q[i]  <= w_pc_n[i];
        r_ins_q[i] <= w_ins_n[i];
      end
      if (redirect_valid) begin
        r_count    <= 3'd0;
        r_fetch_pc <= redirect_pc;
        if (redirect_pc[1:0] == 2'b00) begin
          r_state <= ST_RUN;
          r_fault <= 1'b0;
        end else begin
          r_state    <= ST_FAULT;
          r_fault    <= 1'b1;
          r_fault_pc <= redirect_pc;
        end
      end else begin
        r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + address_data'(4);
        end
        if ((r_state == ST_RUN) && !w_in_range) begin
          r_state    <= ST_FAULT;
          r_fault    <= 1'b1;
          r_fault_pc <= r_fetch_pc;
        end
      end
    end
  end

`ifdef I_FETCH_PERF_EN
  logic [31:0] r_perf_fetches;
  logic [31:0] r_perf_stalls;
  logic        w_stall;

  assign w_stall      = (r_state == ST_RUN) && (r_count == DEPTH) && !w_pop && !redirect_valid;
  assign perf_fetches = r_perf_fetches;
  assign perf_stalls  = r_perf_stalls;

  // Counters saturate and survive redirects; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_fetches <= 32'd0;
      r_perf_stalls  <= 32'd0;
    end else begin
      if (w_push && (r_perf_fetches != 32'hFFFF_FFFF)) begin
        r_perf_fetches <= r_perf_fetches + 32'd1;
      end
      if (w_stall && (r_perf_stalls != 32'hFFFF_FFFF)) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i_fetch_ctrl.sv
// tb/tb_i_fetch_ctrl.sv - directed plus randomized bench for i_fetch_ctrl against a queue model
// Checks perf counters too when I_FETCH_PERF_EN is defined.
module tb_i_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] i_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fault;
  logic [31:0] fault_pc;
`ifdef I_FETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_stalls;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] rom [256];

  // Model state: fetch queue of {pc, instr}, PC, fault flags, perf counts.
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  logic        m_run;
  logic        m_fault;
  logic [31:0] m_fpc;
  logic [31:0] m_pf;
  logic [31:0] m_ps;

  i_fetch_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .address        (address),
    .i_out          (i_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
`ifdef I_FETCH_PERF_EN
    ,
    .perf_fetches   (perf_fetches),
    .perf_stalls    (perf_stalls)
`endif
  );

  always #5 clock = ~clock;

  always_comb begin
    if (address[31:10] == 22'd0) i_out = rom[address[9:2]];
    else                         i_out = 32'hBAD0_0000 ^ address;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit          pop;
    bit          push;
    bit          inr;
    logic [31:0] word;
    if (rst) begin
      m_q.delete();
      m_pc = 32'h0; m_run = 1'b1; m_fault = 1'b0; m_fpc = 32'h0;
      m_pf = 32'h0; m_ps = 32'h0;
    end else if (rv) begin
      m_q.delete();
      m_pc = rpc;
      if (rpc[1:0] == 2'b00) begin
        m_run = 1'b1; m_fault = 1'b0;
      end else begin
        m_run = 1'b0; m_fault = 1'b1; m_fpc = rpc;
      end
    end else begin
      inr  = (m_pc / 4) < 256;
      pop  = (m_q.size() > 0) && rdy;
      push = m_run && inr && ((m_q.size() < 2) || pop);
      word = inr ? rom[m_pc[9:2]] : 32'h0;
      if (m_run && (m_q.size() == 2) && !pop) m_ps++;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, word});
        m_pc = m_pc + 32'd4;
        m_pf++;
      end
      if (m_run && !inr) begin
        m_run = 1'b0; m_fault = 1'b1; m_fpc = m_pc;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
    model_step(rst, rv, rpc, rdy);
    @(posedge clock);
    #1;
    chk("address",   address,          m_pc);
    chk("dec_valid", 32'(dec_valid),   32'(m_q.size() != 0));
    chk("fault",     32'(fault),       32'(m_fault));
    chk("fault_pc",  fault_pc,         m_fpc);
    if (m_q.size() > 0) begin
      chk("dec_pc",    dec_pc,    m_q[0][63:32]);
      chk("dec_instr", dec_instr, m_q[0][31:0]);
    end
`ifdef I_FETCH_PERF_EN
    chk("perf_fetches", perf_fetches, m_pf);
    chk("perf_stalls",  perf_stalls,  m_ps);
`endif
  endtask

  initial begin
    logic [31:0] rpc;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h2008_0001; rom[1] = 32'h2009_0002;
    rom[2] = 32'h0109_5020; rom[3] = 32'hAC0A_0000;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;

    // Reset state
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_dec_pc",    dec_pc,    32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);

    // Streaming with decode always ready
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // Backpressure from a fresh start
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("bp_address", address, 32'h8);
    chk("bp_dec_pc",  dec_pc,  32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Redirect while head is presented and ready is high
    chk("rd_pre_valid", 32'(dec_valid), 32'd1);
    cyc(0, 1, 32'h40, 1);
    chk("rd_valid",   32'(dec_valid), 32'd0);
    chk("rd_address", address,        32'h40);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    // Misaligned redirect then recovery
    cyc(0, 1, 32'h42, 1);
    chk("mis_fault_pc", fault_pc, 32'h42);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h10, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // End of ROM range, with a short stall so entries are left to drain after the fault
    cyc(0, 1, 32'h3F0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, (i > 3));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("end_fault_pc", fault_pc, 32'h400);

    // Reset overrides a simultaneous redirect with a full FIFO
    cyc(0, 1, 32'h20, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h80, 0);
    chk("mid_rst_address", address,        32'h0);
    chk("mid_rst_valid",   32'(dec_valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        1:       rpc = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        2:       rpc = 32'h3E0 + 32'($urandom_range(0, 7) * 4);
        default: rpc = $urandom;
      endcase
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0), rpc,
          ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
